// File: rtl/index_sweep_ctr.sv
// Nested x/y/z index generator sweeping an X_DIM*Y_DIM*Z_DIM state array,
// with two sweep orders, stall, sync clear and a start/busy/done handshake.
module index_sweep_ctr #(
   parameter int X_DIM = 5,
   parameter int Y_DIM = 5,
   parameter int Z_DIM = 64,
   parameter int XW    = 3,
   parameter int YW    = 3,
   parameter int ZW    = 6,
   parameter int LW    = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init0,
   input  logic          start,
   input  logic          order,
   input  logic          enc,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic [ZW-1:0] z,
   output logic [LW-1:0] lin,
   output logic          busy,
   output logic          co,
   output logic          done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [XW-1:0] X_LAST = XW'(X_DIM - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(Y_DIM - 1);
   localparam logic [ZW-1:0] Z_LAST = ZW'(Z_DIM - 1);
   localparam logic [LW-1:0] L_LAST = LW'(X_DIM * Y_DIM * Z_DIM - 1);

   logic [1:0]    r_state;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [ZW-1:0] r_z;
   logic [LW-1:0] r_lin;
   logic          r_order;
   logic          r_done;

   logic          w_x_last;
   logic          w_y_last;
   logic          w_z_last;
   logic          w_busy;
   logic          w_co;
   logic [XW-1:0] w_x_inc;
   logic [YW-1:0] w_y_inc;
   logic [ZW-1:0] w_z_inc;
   logic [XW-1:0] w_x_nxt;
   logic [YW-1:0] w_y_nxt;
   logic [ZW-1:0] w_z_nxt;

   assign w_x_last = (r_x == X_LAST);
   assign w_y_last = (r_y == Y_LAST);
   assign w_z_last = (r_z == Z_LAST);
   assign w_busy   = (r_state == S_RUN);
   // Both orders end on the same point, so one terminal test serves both.
   assign w_co     = w_busy & w_x_last & w_y_last & w_z_last;

   // Per-dimension wrapping increment; a size-1 dimension is always "last".
   always_comb begin
      w_x_inc = w_x_last ? '0 : r_x + 1'b1;
      w_y_inc = w_y_last ? '0 : r_y + 1'b1;
      w_z_inc = w_z_last ? '0 : r_z + 1'b1;
   end

   always_comb begin
      w_x_nxt = r_x;
      w_y_nxt = r_y;
      w_z_nxt = r_z;
      if (!r_order) begin
         w_x_nxt = w_x_inc;
         w_y_nxt = w_x_last ? w_y_inc : r_y;
         w_z_nxt = (w_x_last && w_y_last) ? w_z_inc : r_z;
      end else begin
         w_z_nxt = w_z_inc;
         w_x_nxt = w_z_last ? w_x_inc : r_x;
         w_y_nxt = (w_z_last && w_x_last) ? w_y_inc : r_y;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_lin   <= '0;
         r_order <= 1'b0;
         r_done  <= 1'b0;
      end else if (init0) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_lin   <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= S_RUN;
                  r_order <= order;
               end
            end
            S_RUN: begin
               if (enc) begin
                  if (w_co) begin
                     r_state <= S_DONE;
                     r_x     <= '0;
                     r_y     <= '0;
                     r_z     <= '0;
                     r_lin   <= '0;
                     r_done  <= 1'b1;
                  end else begin
                     r_x     <= w_x_nxt;
                     r_y     <= w_y_nxt;
                     r_z     <= w_z_nxt;
                     r_lin   <= r_lin + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign x    = r_x;
   assign y    = r_y;
   assign z    = r_z;
   assign lin  = r_lin;
   assign busy = w_busy;
   assign co   = w_co;
   assign done = r_done;

   a_idx_range: assert property (@(posedge clk) disable iff (rst)
      (r_x <= X_LAST) && (r_y <= Y_LAST) && (r_z <= Z_LAST) && (r_lin <= L_LAST));
   a_state_legal: assert property (@(posedge clk) disable iff (rst)
      r_state != 2'd3);

endmodule

// File: tb/tb_index_sweep_ctr.sv
// Bench for index_sweep_ctr: default-size and 2x3x1 instances checked against
// a step-count model plus directed tables/sequences.
module tb_index_sweep_ctr;

   typedef struct {
      int ph;   // 0 idle, 1 run, 2 done
      int s;    // points consumed so far in this sweep
      int oq;
   } mdl_t;

   typedef struct {
      int i0, st, od, en;
      int bsy, x, y, z, lin, co, dn;
   } vec_t;

   logic clk, rst;

   logic       a_init0, a_start, a_order, a_enc;
   logic [2:0] a_x, a_y;
   logic [5:0] a_z;
   logic [10:0] a_lin;
   logic       a_busy, a_co, a_done;

   logic       b_init0, b_start, b_order, b_enc;
   logic       b_x;
   logic [1:0] b_y;
   logic       b_z;
   logic [2:0] b_lin;
   logic       b_busy, b_co, b_done;

   int total = 0;
   int bad   = 0;
   mdl_t mA, mB;

   index_sweep_ctr u_a (
      .clk(clk), .rst(rst), .init0(a_init0), .start(a_start), .order(a_order), .enc(a_enc),
      .x(a_x), .y(a_y), .z(a_z), .lin(a_lin), .busy(a_busy), .co(a_co), .done(a_done));

   index_sweep_ctr #(.X_DIM(2), .Y_DIM(3), .Z_DIM(1), .XW(1), .YW(2), .ZW(1), .LW(3)) u_b (
      .clk(clk), .rst(rst), .init0(b_init0), .start(b_start), .order(b_order), .enc(b_enc),
      .x(b_x), .y(b_y), .z(b_z), .lin(b_lin), .busy(b_busy), .co(b_co), .done(b_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic mdl_t mstep(input mdl_t m, input int n, input logic i0,
                                  input logic st, input logic od, input logic en);
      mdl_t r = m;
      if (i0) begin
         r.ph = 0; r.s = 0;
      end else begin
         case (m.ph)
            0: if (st) begin r.ph = 1; r.s = 0; r.oq = od ? 1 : 0; end
            1: if (en) begin
                  if (m.s == n - 1) begin r.ph = 2; r.s = 0; end
                  else r.s = m.s + 1;
               end
            default: r.ph = 0;
         endcase
      end
      return r;
   endfunction

   task automatic exp_out(input mdl_t m, input int X, input int Y, input int Z,
                          output int ex, output int ey, output int ez, output int el,
                          output int eb, output int ec, output int ed);
      ex = 0; ey = 0; ez = 0; el = 0; eb = 0; ec = 0;
      if (m.ph == 1) begin
         if (m.oq == 0) begin
            ex = m.s % X; ey = (m.s / X) % Y; ez = m.s / (X * Y);
         end else begin
            ez = m.s % Z; ex = (m.s / Z) % X; ey = m.s / (Z * X);
         end
         el = m.s; eb = 1; ec = (m.s == X * Y * Z - 1) ? 1 : 0;
      end
      ed = (m.ph == 2) ? 1 : 0;
   endtask

   task automatic cmp_all();
      int ex, ey, ez, el, eb, ec, ed;
      exp_out(mA, 5, 5, 64, ex, ey, ez, el, eb, ec, ed);
      chk("A.x", int'(a_x), ex);       chk("A.y", int'(a_y), ey);
      chk("A.z", int'(a_z), ez);       chk("A.lin", int'(a_lin), el);
      chk("A.busy", int'(a_busy), eb); chk("A.co", int'(a_co), ec);
      chk("A.done", int'(a_done), ed);
      exp_out(mB, 2, 3, 1, ex, ey, ez, el, eb, ec, ed);
      chk("B.x", int'(b_x), ex);       chk("B.y", int'(b_y), ey);
      chk("B.z", int'(b_z), ez);       chk("B.lin", int'(b_lin), el);
      chk("B.busy", int'(b_busy), eb); chk("B.co", int'(b_co), ec);
      chk("B.done", int'(b_done), ed);
   endtask

   task automatic tick();
      @(posedge clk);
      mA = mstep(mA, 1600, a_init0, a_start, a_order, a_enc);
      mB = mstep(mB, 6, b_init0, b_start, b_order, b_enc);
      #1;
      cmp_all();
   endtask

   // Full sweep on the default instance; optional 3-cycle stall at lin=37.
   task automatic sweep_a(input logic od, input bit stall);
      int  cyc;
      bit  stalled = 0;
      a_start = 1'b1; a_order = od; a_enc = 1'b1;
      tick();
      a_start = 1'b0;
      a_order = ~od;  // must not affect the running sweep
      chk("sweep.first_busy", int'(a_busy), 1);
      tick();
      cyc = 2;
      chk("sweep.step2_x", int'(a_x), od ? 0 : 1);
      chk("sweep.step2_z", int'(a_z), od ? 1 : 0);
      while (a_co !== 1'b1 && cyc < 2000) begin
         if (stall && !stalled && a_lin == 11'd37) begin
            a_enc = 1'b0;
            repeat (3) begin
               tick(); cyc++;
               chk("stall.lin", int'(a_lin), 37);
               chk("stall.co", int'(a_co), 0);
            end
            a_enc = 1'b1;
            stalled = 1;
         end else begin
            tick(); cyc++;
         end
      end
      chk("sweep.co_cycle", cyc, stall ? 1603 : 1600);
      chk("sweep.last_x", int'(a_x), 4);
      chk("sweep.last_y", int'(a_y), 4);
      chk("sweep.last_z", int'(a_z), 63);
      chk("sweep.last_lin", int'(a_lin), 1599);
      tick();
      chk("sweep.done", int'(a_done), 1);
      chk("sweep.done_busy", int'(a_busy), 0);
      chk("sweep.done_lin", int'(a_lin), 0);
      tick();
      chk("sweep.idle_done", int'(a_done), 0);
      chk("sweep.idle_x", int'(a_x), 0);
   endtask

   vec_t tbl[14];

   initial begin
      int k;
      tbl[0]  = '{0,1,0,0, 1,0,0,0,0,0,0};
      tbl[1]  = '{0,0,0,1, 1,1,0,0,1,0,0};
      tbl[2]  = '{0,0,0,1, 1,0,1,0,2,0,0};
      tbl[3]  = '{0,0,0,0, 1,0,1,0,2,0,0};
      tbl[4]  = '{0,0,0,1, 1,1,1,0,3,0,0};
      tbl[5]  = '{0,0,0,1, 1,0,2,0,4,0,0};
      tbl[6]  = '{0,0,0,1, 1,1,2,0,5,1,0};
      tbl[7]  = '{0,1,0,0, 1,1,2,0,5,1,0};
      tbl[8]  = '{0,0,0,1, 0,0,0,0,0,0,1};
      tbl[9]  = '{0,1,0,1, 0,0,0,0,0,0,0};
      tbl[10] = '{0,1,1,0, 1,0,0,0,0,0,0};
      tbl[11] = '{0,0,0,1, 1,1,0,0,1,0,0};
      tbl[12] = '{1,1,0,1, 0,0,0,0,0,0,0};
      tbl[13] = '{0,0,0,0, 0,0,0,0,0,0,0};

      rst = 1'b1;
      {a_init0, a_start, a_order, a_enc} = '0;
      {b_init0, b_start, b_order, b_enc} = '0;
      mA = '{0, 0, 0};
      mB = '{0, 0, 0};
      repeat (2) @(posedge clk);
      #1;
      chk("reset.busy", int'(a_busy), 0);
      chk("reset.lin", int'(a_lin), 0);
      chk("reset.co", int'(a_co), 0);
      chk("reset.done", int'(a_done), 0);
      cmp_all();
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Small 2x3x1 instance: directed vectors
      for (int i = 0; i < 14; i++) begin
         b_init0 = (tbl[i].i0 != 0); b_start = (tbl[i].st != 0);
         b_order = (tbl[i].od != 0); b_enc   = (tbl[i].en != 0);
         tick();
         chk("tbl.busy", int'(b_busy), tbl[i].bsy);
         chk("tbl.x", int'(b_x), tbl[i].x);
         chk("tbl.y", int'(b_y), tbl[i].y);
         chk("tbl.z", int'(b_z), tbl[i].z);
         chk("tbl.lin", int'(b_lin), tbl[i].lin);
         chk("tbl.co", int'(b_co), tbl[i].co);
         chk("tbl.done", int'(b_done), tbl[i].dn);
      end
      {b_init0, b_start, b_order, b_enc} = '0;

      sweep_a(1'b0, 0);
      sweep_a(1'b1, 0);
      sweep_a(1'b0, 1);

      // init0 at lin=500 with start pulses sprinkled through RUN
      a_start = 1'b1; a_order = 1'b0; a_enc = 1'b1;
      tick();
      k = 0;
      while (a_lin != 11'd500 && k < 1000) begin
         a_start = (k % 7 == 3);
         tick(); k++;
      end
      chk("init0.reach500", int'(a_lin), 500);
      a_start = 1'b1; a_init0 = 1'b1;
      tick();
      a_start = 1'b0; a_init0 = 1'b0;
      chk("init0.busy", int'(a_busy), 0);
      chk("init0.lin", int'(a_lin), 0);
      chk("init0.x", int'(a_x), 0);
      chk("init0.done", int'(a_done), 0);
      repeat (3) tick();

      // Async reset in the middle of a sweep
      a_start = 1'b1; a_order = 1'b1;
      tick();
      a_start = 1'b0;
      repeat (20) tick();
      #3 rst = 1'b1;
      #2;
      chk("arst.busy", int'(a_busy), 0);
      chk("arst.lin", int'(a_lin), 0);
      chk("arst.z", int'(a_z), 0);
      chk("arst.done", int'(a_done), 0);
      mA = '{0, 0, 0};
      mB = '{0, 0, 0};
      cmp_all();
      #1 rst = 1'b0;
      repeat (3) tick();

      // Randomised run on both instances
      for (int i = 0; i < 4000; i++) begin
         a_init0 = ($urandom_range(0, 499) == 0);
         a_start = ($urandom_range(0, 4) == 0);
         a_order = 1'($urandom);
         a_enc   = ($urandom_range(0, 9) < 8);
         b_init0 = ($urandom_range(0, 39) == 0);
         b_start = ($urandom_range(0, 2) == 0);
         b_order = 1'($urandom);
         b_enc   = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
